// File: rtl/ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
package ocimem_pkg;

    localparam int unsigned JDO_W         = 38;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned JDO_LDADDR    = 35;
    localparam int unsigned JDO_RDAFTER   = 34;
    localparam int unsigned JDO_CLRERR    = 33;
    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_WDATA_LSB = 3;

    typedef enum logic [1:0] {IDLE, JRD, JWR, CRD} state_t;

    // Kind of JTAG event held in the pending slot
    typedef enum logic [1:0] {EV_NOP, EV_RDA, EV_RDN, EV_WR} ev_t;

    typedef struct packed {
        ev_t               kind;
        logic [DATA_W-1:0] wdata;
    } jtag_ev_t;

endpackage

// File: rtl/proyecto3_system_nios_ii_processor_cpu_ocimem_ram.sv
// Single-port debug RAM: byte-enable write, registered 1-cycle read.
module proyecto3_system_nios_ii_processor_cpu_ocimem_ram
    import ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/blk_7001e3.sv
// OCI debug-memory controller: JTAG monitor command decode plus a CPU slave window
// onto the same debug RAM, with JTAG traffic taking priority.
module blk_7001e3
    import ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [BE_W-1:0]   av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    state_t            state, state_nxt;
    logic              pend, pend_clr;
    jtag_ev_t          pend_ev, cap_ev;
    logic [ADDR_W-1:0] mon_areg;
    logic [DATA_W-1:0] readdata_q;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata, ram_q;

    logic strobe_any, strobe_multi, accept, accept_a;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_LDADDR+1], jdo[JDO_WDATA_LSB-1:0]};

    // Strobe capture: one pending slot, ocimem_b > no_action_a > action_a
    assign strobe_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign strobe_multi = (take_action_ocimem_b & (take_no_action_ocimem_a | take_action_ocimem_a))
                        | (take_no_action_ocimem_a & take_action_ocimem_a);
    assign accept       = strobe_any & ~pend;
    assign accept_a     = accept & take_action_ocimem_a & ~take_action_ocimem_b & ~take_no_action_ocimem_a;

    always_comb begin
        cap_ev = '{kind: EV_NOP, wdata: jdo[JDO_WDATA_LSB +: DATA_W]};
        if (take_action_ocimem_b)         cap_ev.kind = EV_WR;
        else if (take_no_action_ocimem_a) cap_ev.kind = EV_RDN;
        else if (jdo[JDO_RDAFTER])        cap_ev.kind = EV_RDA;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A strobe arriving this cycle also holds off the CPU so JTAG is served first
    always_comb begin
        state_nxt      = state;
        pend_clr       = 1'b0;
        ram_addr       = mon_areg;
        ram_we         = 1'b0;
        ram_be         = '1;
        ram_wdata      = pend_ev.wdata;
        av_waitrequest = av_read | av_write;
        case (state)
            IDLE: begin
                if (pend) begin
                    case (pend_ev.kind)
                        EV_WR: begin
                            ram_we    = 1'b1;
                            state_nxt = JWR;
                        end
                        EV_RDA, EV_RDN: state_nxt = JRD;
                        default:        pend_clr  = 1'b1;
                    endcase
                end else if (!strobe_any) begin
                    ram_addr = av_address;
                    if (av_read) begin
                        state_nxt = CRD;
                    end else if (av_write) begin
                        ram_we         = 1'b1;
                        ram_be         = av_byteenable;
                        ram_wdata      = av_writedata;
                        av_waitrequest = 1'b0;
                    end
                end
            end
            JRD, JWR: begin
                pend_clr  = 1'b1;
                state_nxt = IDLE;
            end
            CRD: begin
                av_waitrequest = 1'b0;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= 1'b0;
            pend_ev <= '0;
        end else if (pend_clr) begin
            pend    <= 1'b0;
        end else if (accept) begin
            pend    <= 1'b1;
            pend_ev <= cap_ev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_areg      <= '0;
            MonDReg       <= '0;
            readdata_q    <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (state == JRD) MonDReg    <= ram_q;
            if (state == CRD) readdata_q <= ram_q;

            if (accept_a)      monitor_ready <= 1'b0;
            else if (pend_clr) monitor_ready <= 1'b1;

            if (accept_a && jdo[JDO_LDADDR])
                mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
            else if (pend_clr && (pend_ev.kind == EV_RDN || pend_ev.kind == EV_WR))
                mon_areg <= mon_areg + ADDR_W'(1);

            if (strobe_any && (pend || strobe_multi))  monitor_error <= 1'b1;
            else if (accept_a && jdo[JDO_CLRERR])      monitor_error <= 1'b0;
        end
    end

    // Read data is live from the RAM in the completing cycle, then held
    assign av_readdata = (state == CRD) ? ram_q : readdata_q;

    proyecto3_system_nios_ii_processor_cpu_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_blk_7001e3.sv
// Directed self-checking bench for blk_7001e3 (ADDR_W = 8).
module tb_blk_7001e3;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    blk_7001e3 #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [37:0] mk_a(input logic ld, input logic rd, input logic clr,
                                         input logic [7:0] addr);
        logic [37:0] j;
        j        = '0;
        j[35]    = ld;
        j[34]    = rd;
        j[33]    = clr;
        j[24:17] = addr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic jtag_a(input logic [37:0] j);
        take_action_ocimem_a = 1'b1;
        jdo = j;
        cyc();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        take_action_ocimem_b = 1'b1;
        jdo = mk_b(d);
        cyc();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_na();
        take_no_action_ocimem_a = 1'b1;
        cyc();
        take_no_action_ocimem_a = 1'b0;
    endtask

    initial begin
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        av_address              = '0;
        av_read                 = 1'b0;
        av_write                = 1'b0;
        av_writedata            = '0;
        av_byteenable           = 4'hF;
        idle(2);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'd0);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_wait", 32'(av_waitrequest), 32'd0);
        reset_n = 1'b1;
        cyc();

        // 1: load address 0x10, JTAG writes, post-increment
        jtag_a(mk_a(1'b1, 1'b0, 1'b0, 8'h10));
        chk("t1_ready_clr", 32'(monitor_ready), 32'd0);
        cyc();
        chk("t1_ready_rearm", 32'(monitor_ready), 32'd1);
        jtag_b(32'hDEADBEEF);
        idle(2);
        chk("t1_ready_wr", 32'(monitor_ready), 32'd1);
        jtag_b(32'h12345678);
        idle(2);

        // 2: load 0x10 with read-after; no increment on that read
        jtag_a(mk_a(1'b1, 1'b1, 1'b0, 8'h10));
        chk("t2_ready_clr", 32'(monitor_ready), 32'd0);
        cyc();
        chk("t2_ready_lat1", 32'(monitor_ready), 32'd0);
        cyc();
        chk("t2_ready", 32'(monitor_ready), 32'd1);
        chk("t2_mondreg", MonDReg, 32'hDEADBEEF);
        jtag_na();
        idle(2);
        chk("t2_na_same_addr", MonDReg, 32'hDEADBEEF);
        jtag_na();
        idle(2);
        chk("t2_na_incr", MonDReg, 32'h12345678);

        // 3: address wrap at 0xFF
        jtag_a(mk_a(1'b1, 1'b0, 1'b0, 8'hFF));
        idle(2);
        jtag_b(32'hCAFEF00D);
        idle(2);
        jtag_b(32'h0BADC0DE);
        idle(2);
        jtag_a(mk_a(1'b1, 1'b0, 1'b0, 8'hFF));
        idle(2);
        jtag_na();
        idle(2);
        chk("t3_rd_ff", MonDReg, 32'hCAFEF00D);
        jtag_na();
        idle(2);
        chk("t3_rd_wrap", MonDReg, 32'h0BADC0DE);
        chk("t3_no_error", 32'(monitor_error), 32'd0);

        // 4: CPU read colliding with a JTAG write to the same word
        jtag_a(mk_a(1'b1, 1'b0, 1'b0, 8'h10));
        idle(2);
        take_action_ocimem_b = 1'b1;
        jdo        = mk_b(32'hA5A55A5A);
        av_read    = 1'b1;
        av_address = 8'h10;
        #1;
        chk("t4_wait_strobe", 32'(av_waitrequest), 32'd1);
        cyc();
        take_action_ocimem_b = 1'b0;
        #1;
        chk("t4_wait_pend", 32'(av_waitrequest), 32'd1);
        cyc();
        chk("t4_wait_jwr", 32'(av_waitrequest), 32'd1);
        cyc();
        chk("t4_wait_idle", 32'(av_waitrequest), 32'd1);
        chk("t4_jtag_ready", 32'(monitor_ready), 32'd1);
        cyc();
        chk("t4_wait_crd", 32'(av_waitrequest), 32'd0);
        chk("t4_rdata_crd", av_readdata, 32'hA5A55A5A);
        cyc();
        av_read = 1'b0;
        #1;
        chk("t4_rdata_hold", av_readdata, 32'hA5A55A5A);
        chk("t4_wait_bus_idle", 32'(av_waitrequest), 32'd0);

        // 5: strobes during a CPU read; the second one is dropped
        av_read    = 1'b1;
        av_address = 8'h11;
        cyc();
        take_no_action_ocimem_a = 1'b1;
        #1;
        chk("t5_rdata_crd", av_readdata, 32'h12345678);
        chk("t5_wait_crd", 32'(av_waitrequest), 32'd0);
        cyc();
        take_no_action_ocimem_a = 1'b0;
        av_read = 1'b0;
        take_action_ocimem_a = 1'b1;
        jdo = mk_a(1'b1, 1'b0, 1'b0, 8'h20);
        cyc();
        take_action_ocimem_a = 1'b0;
        chk("t5_error_set", 32'(monitor_error), 32'd1);
        cyc();
        chk("t5_first_read", MonDReg, 32'h12345678);
        jtag_a(mk_a(1'b0, 1'b0, 1'b1, 8'h00));
        chk("t5_error_clr", 32'(monitor_error), 32'd0);
        chk("t5_ready_clr", 32'(monitor_ready), 32'd0);
        cyc();
        chk("t5_ready_rearm", 32'(monitor_ready), 32'd1);
        cyc();
        take_action_ocimem_b    = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        jdo = mk_b(32'h600DF00D);
        cyc();
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        chk("t5_same_cycle_err", 32'(monitor_error), 32'd1);
        idle(2);
        jtag_a(mk_a(1'b1, 1'b1, 1'b1, 8'h12));
        idle(2);
        chk("t5_b_won", MonDReg, 32'h600DF00D);
        chk("t5_error_clr2", 32'(monitor_error), 32'd0);

        // 6: CPU byte-lane write, then reset in the middle of a JTAG read
        av_write      = 1'b1;
        av_address    = 8'h10;
        av_byteenable = 4'b0010;
        av_writedata  = 32'h0000AB00;
        #1;
        chk("t6_wait_write", 32'(av_waitrequest), 32'd0);
        cyc();
        av_write      = 1'b0;
        av_byteenable = 4'hF;
        av_read       = 1'b1;
        #1;
        chk("t6_wait_rd", 32'(av_waitrequest), 32'd1);
        cyc();
        chk("t6_byte_lane", av_readdata, 32'hA5A5AB5A);
        cyc();
        av_read = 1'b0;
        jtag_a(mk_a(1'b1, 1'b1, 1'b0, 8'h10));
        cyc();
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_mondreg", MonDReg, 32'h0);
        chk("t6_rst_readdata", av_readdata, 32'h0);
        chk("t6_rst_ready", 32'(monitor_ready), 32'd0);
        chk("t6_rst_error", 32'(monitor_error), 32'd0);
        chk("t6_rst_wait", 32'(av_waitrequest), 32'd0);
        cyc();
        reset_n = 1'b1;
        idle(3);
        chk("t6_post_rst_mondreg", MonDReg, 32'h0);
        chk("t6_post_rst_ready", 32'(monitor_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
